// File: rtl/mult_div_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encodings, FSM state encoding and small opcode decode helpers.
package mult_div_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } opT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_ZDIV = 2'b11
  } stateT;

  function automatic logic isDiv(input opT o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic isSigned(input opT o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the A/B operand registers, the multiply/divide
// unit and the Hi/Lo result registers.
interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  import mult_div_seq_pkg::*;

  logic             start;
  opT               op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, hi, lo, div_zero
  );

endinterface

// File: rtl/mult_div_seq_sign_mag_conv.sv
// Conditional two's-complement negate. With neg tied to the sign bit it yields
// abs(x); the most negative value maps onto its unsigned magnitude 2^(WIDTH-1).
module sign_mag_conv #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/mult_div_seq.sv
// WIDTH-generic sequential multiplier / restoring divider. Operands are taken as
// magnitudes at start, iterated WIDTH times, then sign-corrected into hi/lo.
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mult_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  stateT            stateReg, stateNext;
  opT               opReg, opNext;
  logic             negLoReg, negLoNext;
  logic             negHiReg, negHiNext;
  logic [WIDTH-1:0] mcandReg, mcandNext;
  logic [WIDTH-1:0] workHiReg, workHiNext;
  logic [WIDTH-1:0] workLoReg, workLoNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic             busyReg, busyNext;
  logic             doneReg, doneNext;
  logic [WIDTH-1:0] hiReg, hiNext;
  logic [WIDTH-1:0] loReg, loNext;
  logic             divZeroReg, divZeroNext;

  opT               opIn;
  logic             signedIn;
  logic [WIDTH-1:0] capIn  [2];
  logic [WIDTH-1:0] capMag [2];

  assign opIn     = bus.op;
  assign signedIn = isSigned(opIn);
  assign capIn[0] = bus.a_in;
  assign capIn[1] = bus.b_in;

  // Operand magnitudes: index 0 is the multiplicand/dividend, 1 the multiplier/divisor.
  for (genvar gi = 0; gi < 2; gi++) begin : gCapture
    sign_mag_conv #(.WIDTH(WIDTH)) uAbs (
      .x  (capIn[gi]),
      .neg(signedIn & capIn[gi][WIDTH-1]),
      .y  (capMag[gi])
    );
  end

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  sign_mag_conv #(.WIDTH(2*WIDTH)) uFixProd (
    .x  ({workHiReg, workLoReg}),
    .neg(negLoReg),
    .y  (prodFix)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) uFixQuot (
    .x  (workLoReg),
    .neg(negLoReg),
    .y  (quotFix)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) uFixRem (
    .x  (workHiReg),
    .neg(negHiReg),
    .y  (remFix)
  );

  // One shift-add step (multiply) and one shift-subtract step (divide). The
  // partial remainder is always below the divisor, so WIDTH+1 bits suffice.
  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] divShift;
  logic [WIDTH:0] divDiff;

  assign mulSum   = {1'b0, workHiReg} + (workLoReg[0] ? {1'b0, mcandReg} : '0);
  assign divShift = {workHiReg, workLoReg[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, mcandReg};

  always_comb begin
    stateNext   = stateReg;
    opNext      = opReg;
    negLoNext   = negLoReg;
    negHiNext   = negHiReg;
    mcandNext   = mcandReg;
    workHiNext  = workHiReg;
    workLoNext  = workLoReg;
    cntNext     = cntReg;
    busyNext    = busyReg;
    doneNext    = 1'b0;
    hiNext      = hiReg;
    loNext      = loReg;
    divZeroNext = divZeroReg;

    unique case (stateReg)
      ST_IDLE: begin
        if (bus.start) begin
          opNext      = opIn;
          negLoNext   = signedIn & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
          negHiNext   = signedIn & bus.a_in[WIDTH-1];
          cntNext     = '0;
          divZeroNext = 1'b0;
          busyNext    = 1'b1;
          workHiNext  = '0;
          if (isDiv(opIn)) begin
            workLoNext = capMag[0];
            mcandNext  = capMag[1];
            stateNext  = (bus.b_in == '0) ? ST_ZDIV : ST_CALC;
          end else begin
            workLoNext = capMag[1];
            mcandNext  = capMag[0];
            stateNext  = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (isDiv(opReg)) begin
          if (!divDiff[WIDTH]) begin
            workHiNext = divDiff[WIDTH-1:0];
            workLoNext = {workLoReg[WIDTH-2:0], 1'b1};
          end else begin
            workHiNext = divShift[WIDTH-1:0];
            workLoNext = {workLoReg[WIDTH-2:0], 1'b0};
          end
        end else begin
          workHiNext = mulSum[WIDTH:1];
          workLoNext = {mulSum[0], workLoReg[WIDTH-1:1]};
        end
        cntNext = cntReg + 1'b1;
        if (cntReg == CNT_W'(WIDTH - 1)) begin
          stateNext = ST_FIX;
        end
      end

      ST_FIX: begin
        if (isDiv(opReg)) begin
          hiNext = remFix;
          loNext = quotFix;
        end else begin
          {hiNext, loNext} = prodFix;
        end
        doneNext  = 1'b1;
        busyNext  = 1'b0;
        stateNext = ST_IDLE;
      end

      ST_ZDIV: begin
        doneNext    = 1'b1;
        divZeroNext = 1'b1;
        busyNext    = 1'b0;
        stateNext   = ST_IDLE;
      end

      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= ST_IDLE;
      opReg      <= OP_MULT;
      negLoReg   <= 1'b0;
      negHiReg   <= 1'b0;
      mcandReg   <= '0;
      workHiReg  <= '0;
      workLoReg  <= '0;
      cntReg     <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      divZeroReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      opReg      <= opNext;
      negLoReg   <= negLoNext;
      negHiReg   <= negHiNext;
      mcandReg   <= mcandNext;
      workHiReg  <= workHiNext;
      workLoReg  <= workLoNext;
      cntReg     <= cntNext;
      busyReg    <= busyNext;
      doneReg    <= doneNext;
      hiReg      <= hiNext;
      loReg      <= loNext;
      divZeroReg <= divZeroNext;
    end
  end

  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
  assign bus.div_zero = divZeroReg;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq at WIDTH=32 and WIDTH=8: drivers push
// expected results from an arithmetic reference model, monitors pop on done.
module tb_mult_div_seq;
  import mult_div_seq_pkg::*;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dz;
    int          kEdge;
    int          lat;
  } expT;

  logic clk = 1'b0;
  logic reset32, reset8;
  int   cyc  = 0;
  int   nVec = 0;
  int   nErr = 0;
  expT  q32[$];
  expT  q8[$];
  logic [63:0] last32Hi = '0, last32Lo = '0, last8Hi = '0, last8Lo = '0;
  bit   proc8Done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_div_seq_if #(.WIDTH(32)) bus32 ();
  mult_div_seq_if #(.WIDTH(8))  bus8 ();

  mult_div_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .bus(bus32));
  mult_div_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on sign-extended values.
  function automatic expT model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                input int w, input logic [63:0] pHi, input logic [63:0] pLo);
    expT         e;
    logic [63:0] mask, t1, t2;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - longint'(64'd1 << w);
    if (b[w-1]) sb = sb - longint'(64'd1 << w);
    e.dz = 1'b0; e.lat = w + 1; e.kEdge = 0; e.hi = pHi; e.lo = pLo;
    case (op)
      2'd0: begin t1 = sa * sb; e.hi = (t1 >> w) & mask; e.lo = t1 & mask; end
      2'd1: begin t1 = a * b;   e.hi = (t1 >> w) & mask; e.lo = t1 & mask; end
      default: begin
        if (b == 64'd0) begin
          e.dz = 1'b1; e.lat = 1;
        end else if (op == 2'd2) begin
          t1 = sa / sb; t2 = sa % sb; e.lo = t1 & mask; e.hi = t2 & mask;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 6))
      0: return 8'h0;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h1;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    expT e;
    e = model(op, 64'(a), 64'(b), 32, last32Hi, last32Lo);
    e.kEdge = cyc + 1;
    q32.push_back(e);
    last32Hi = e.hi; last32Lo = e.lo;
    bus32.start = 1'b1; bus32.op = opT'(op); bus32.a_in = a; bus32.b_in = b;
    @(negedge clk);
    bus32.start = 1'b0; bus32.op = opT'($urandom_range(0, 3));
    bus32.a_in = $urandom; bus32.b_in = $urandom;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    expT e;
    e = model(op, 64'(a), 64'(b), 8, last8Hi, last8Lo);
    e.kEdge = cyc + 1;
    q8.push_back(e);
    last8Hi = e.hi; last8Lo = e.lo;
    bus8.start = 1'b1; bus8.op = opT'(op); bus8.a_in = a; bus8.b_in = b;
    @(negedge clk);
    bus8.start = 1'b0; bus8.op = opT'($urandom_range(0, 3));
    bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom);
  endtask

  task automatic waitDone32();
    for (int i = 0; i < 100 && !bus32.done; i++) @(negedge clk);
  endtask

  task automatic waitDone8();
    for (int i = 0; i < 100 && !bus8.done; i++) @(negedge clk);
  endtask

  task automatic waitIdle32();
    for (int i = 0; i < 100 && q32.size() != 0; i++) @(negedge clk);
    chk("w32 outstanding", 64'(q32.size()), 0);
    q32.delete();
  endtask

  task automatic waitIdle8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    chk("w8 outstanding", 64'(q8.size()), 0);
    q8.delete();
  endtask

  int   run32 = 0, run8 = 0;
  logic prevDone32 = 1'b0, prevDone8 = 1'b0;

  always @(negedge clk) begin
    expT e;
    if (reset32) begin
      run32 = 0; prevDone32 = 1'b0;
    end else begin
      if (bus32.busy) run32++;
      if (bus32.done) begin
        chk("w32 done_gap", prevDone32, 0);
        chk("w32 done_busy", bus32.busy, 0);
        if (q32.size() == 0) begin
          nVec++; nErr++;
          $display("FAIL w32 spurious_done: got done with hi=0x%0h lo=0x%0h, want none", bus32.hi, bus32.lo);
        end else begin
          e = q32.pop_front();
          $display("w32 done: hi=0x%h lo=0x%h dz=%0b", bus32.hi, bus32.lo, bus32.div_zero);
          chk("w32 hi", bus32.hi, e.hi);
          chk("w32 lo", bus32.lo, e.lo);
          chk("w32 div_zero", bus32.div_zero, e.dz);
          chk("w32 latency", 64'(cyc - e.kEdge), 64'(e.lat));
          chk("w32 busy_cycles", 64'(run32), 64'(e.lat));
        end
        run32 = 0;
      end
      prevDone32 = bus32.done;
    end
  end

  always @(negedge clk) begin
    expT e;
    if (reset8) begin
      run8 = 0; prevDone8 = 1'b0;
    end else begin
      if (bus8.busy) run8++;
      if (bus8.done) begin
        chk("w8 done_gap", prevDone8, 0);
        if (q8.size() == 0) begin
          nVec++; nErr++;
          $display("FAIL w8 spurious_done: got done with hi=0x%0h lo=0x%0h, want none", bus8.hi, bus8.lo);
        end else begin
          e = q8.pop_front();
          $display("w8 done: hi=0x%h lo=0x%h dz=%0b", bus8.hi, bus8.lo, bus8.div_zero);
          chk("w8 hi", bus8.hi, e.hi);
          chk("w8 lo", bus8.lo, e.lo);
          chk("w8 div_zero", bus8.div_zero, e.dz);
          chk("w8 latency", 64'(cyc - e.kEdge), 64'(e.lat));
          chk("w8 busy_cycles", 64'(run8), 64'(e.lat));
        end
        run8 = 0;
      end
      prevDone8 = bus8.done;
    end
  end

  initial begin
    bus32.start = 1'b0; bus32.op = OP_MULT; bus32.a_in = '0; bus32.b_in = '0;
    reset32 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", bus32.busy, 0);
    chk("reset done", bus32.done, 0);
    chk("reset hi", bus32.hi, 0);
    chk("reset lo", bus32.lo, 0);
    chk("reset div_zero", bus32.div_zero, 0);
    reset32 = 1'b0;
    @(negedge clk);

    issue32(2'd0, 32'hFFFF_FFFD, 32'd7);          waitIdle32();
    issue32(2'd1, 32'hFFFF_FFFF, 32'd2);          waitIdle32();
    issue32(2'd2, 32'hFFFF_FFF9, 32'd2);          waitDone32();
    issue32(2'd3, 32'd5, 32'd0);                  waitDone32();
    issue32(2'd3, 32'd9, 32'd3);                  waitIdle32();
    issue32(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    // Start requests while busy must be dropped without disturbing the result.
    repeat (2) begin
      repeat (4) @(negedge clk);
      bus32.start = 1'b1; bus32.op = opT'($urandom_range(0, 3));
      bus32.a_in = $urandom; bus32.b_in = $urandom;
      @(negedge clk);
      bus32.start = 1'b0;
    end
    waitIdle32();

    for (int i = 0; i < 40; i++) begin
      issue32(2'($urandom_range(0, 3)), pick32(), pick32());
      if (i % 2 == 1) waitDone32();
      else waitIdle32();
    end
    waitIdle32();

    // Abort mid-calculation: outputs clear asynchronously and no done follows.
    issue32(2'd1, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #2 reset32 = 1'b1;
    #1;
    chk("abort busy", bus32.busy, 0);
    chk("abort done", bus32.done, 0);
    chk("abort hi", bus32.hi, 0);
    chk("abort lo", bus32.lo, 0);
    chk("abort div_zero", bus32.div_zero, 0);
    q32.delete();
    last32Hi = '0; last32Lo = '0;
    @(negedge clk);
    @(negedge clk);
    reset32 = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort stays idle", bus32.busy, 0);
    issue32(2'd0, pick32(), pick32());
    waitIdle32();

    for (int i = 0; i < 3000 && !proc8Done; i++) @(negedge clk);
    chk("w8 sequence finished", 64'(proc8Done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    bus8.start = 1'b0; bus8.op = OP_MULT; bus8.a_in = '0; bus8.b_in = '0;
    reset8 = 1'b1;
    repeat (3) @(negedge clk);
    reset8 = 1'b0;
    @(negedge clk);
    issue8(2'd1, 8'hFF, 8'hFF);
    waitIdle8();
    issue8(2'd2, 8'h80, 8'hFF);
    waitIdle8();
    for (int i = 0; i < 30; i++) begin
      issue8(2'($urandom_range(0, 3)), pick8(), pick8());
      if (i % 3 == 0) waitDone8();
      else waitIdle8();
    end
    waitIdle8();
    proc8Done = 1'b1;
  end

endmodule
